serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial ripple adder that adds two WIDTH-bit operands LSB-first, one bit per clock.
//   It is built from two half-adder cells plus a carry flip-flop.
//   It sits downstream of the half-adder cell and consumes its sum/carry outputs every cycle.
//   It provides a small-area adder with valid/ready handshakes on both the operand and result sides.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range WIDTH >= 1
// PORTS
//   clk        input   1      single clock; all state updates on its rising edge
//   rst_n      input   1      asynchronous, active-low reset
//   in_valid   input   1      operands a, b, cin are valid
//   in_ready   output  1      block can accept operands (high only in IDLE)
//   a          input   WIDTH  operand A
//   b          input   WIDTH  operand B
//   cin        input   1      carry-in
//   out_valid  output  1      sum/cout hold a completed result
//   out_ready  input   1      consumer accepts the result
//   sum        output  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       output  1      carry-out of the WIDTH-bit addition
//   busy       output  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n low, applied asynchronously):
//   - state=IDLE; shift regs, carry reg, bit counter, sum and cout all cleared to 0.
//   - out_valid=0, busy=0, in_ready=1 (decoded from state=IDLE).
//   States:
//   - IDLE: in_ready=1. On in_valid&in_ready at an edge: load A_sh=a, B_sh=b, C=cin, cnt=0, clear sum reg; go to RUN.
//   - RUN: each edge, with bit s = A_sh[0]^B_sh[0]^C:
//     - sum reg shifts right with s entering at the MSB.
//     - C <= (A_sh[0]&B_sh[0]) | (C&(A_sh[0]^B_sh[0])), i.e. half-adder 1 on a,b and half-adder 2 on (s1,C).
//     - A_sh and B_sh shift right, zero-filled; cnt++.
//     - On the edge where cnt==WIDTH-1, go to DONE; C is then the final cout.
//   - DONE: out_valid=1; sum and cout stable. On out_valid&out_ready at an edge, go to IDLE.
//     - Sum reg and cout keep their value until the next operand load.
//   Latency:
//   - Operands accepted at edge k; out_valid rises after edge k+WIDTH.
//   - Throughput is one result per WIDTH+2 cycles at best (accept, WIDTH shifts, handoff).
//   Handshake rules:
//   - in_valid while not IDLE is ignored; operands are not captured and not queued.
//   - out_ready while not DONE has no effect.
//   - Back-to-back: in_ready goes high the cycle after the result handoff; no overlap of accept and deliver.
//   - a, b, cin only need to be stable at the accepting edge.
//   Width/arithmetic:
//   - cnt is $clog2(WIDTH+1) bits; cnt never exceeds WIDTH-1.
//   - WIDTH=1 gives exactly one RUN cycle.
//   Boundaries:
//   - Reset mid-RUN or in DONE aborts the operation; the partial result is discarded and no out_valid pulse occurs.
//   - All-ones + 1 wraps sum to 0 with cout=1.
//   - out_ready held low keeps DONE indefinitely with outputs frozen.
// TESTING
//   1. WIDTH=8, a=0x00 b=0x00 cin=0 -> out_valid 8 cycles after accept; sum=0x00, cout=0.
//   2. a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1.
//      Then a=0xA5 b=0x5A cin=1 -> sum=0x00, cout=1.
//   3. a=0x3C b=0x42 cin=0 with out_ready low 5 cycles -> out_valid and sum=0x7E/cout=0 held; IDLE one edge after out_ready=1.
//   4. Pulse in_valid with a=0x11 during RUN of op 0x01+0x01 -> ignored; result sum=0x02, in_ready stays 0 until handoff.
//   5. Assert rst_n=0 asynchronously 3 cycles into RUN -> out_valid=0, busy=0, sum=0, in_ready=1 immediately.
//      Next op 0x80+0x80 -> sum=0x00, cout=1.
//   6. WIDTH=1 build, all 8 a/b/cin combos -> {cout,sum} matches a+b+cin; out_valid 1 cycle after accept.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, LSB first, one bit per clock.
// Two half-adder cells plus a carry flop form the full-adder slice.
// Valid/ready handshakes are used on both the operand side and the result side.
`timescale 1ns/1ps
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Half-adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       ha1_s;
    logic [1:0]       ha2_s;
    logic             bit_s;
    logic             carry_next_s;

    // First cell adds the operand bits; second cell folds in the running carry.
    assign ha1_s        = half_add(a_sh_q[0], b_sh_q[0]);
    assign ha2_s        = half_add(ha1_s[0], carry_q);
    assign bit_s        = ha2_s[0];
    assign carry_next_s = ha1_s[1] | ha2_s[1];

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = bit_s;
                carry_d          = carry_next_s;
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    // Counter is held here so it never passes WIDTH-1.
                    cout_d  = carry_next_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: an 8-bit instance and a 1-bit instance, compared against a+b+cin.
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv8 = 1'b0, ir8, cin8 = 1'b0, ov8, or8 = 1'b0, cout8, busy8;
    logic [7:0] a8 = 8'd0, b8 = 8'd0, sum8;

    logic       iv1 = 1'b0, ir1, cin1 = 1'b0, ov1, or1 = 1'b0, cout1, busy1;
    logic [0:0] a1 = 1'b0, b1 = 1'b0, sum1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .busy(busy1)
    );

    // Reference result: plain integer addition, {cout,sum}.
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // Present operands for one edge, then count cycles until out_valid (bounded).
    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                       output int lat, output logic [7:0] s_o, output logic c_o);
        iv8 = 1'b1; a8 = ai; b8 = bi; cin8 = ci;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s_o = sum8;
        c_o = cout8;
    endtask

    task automatic handoff8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++; if (ir8 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", ir8); else pass_cnt++;
        total_cnt++; if (ov8 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", ov8); else pass_cnt++;
        total_cnt++; if (busy8 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy8); else pass_cnt++;
        total_cnt++; if ({cout8, sum8} !== 9'h000) $display("FAIL reset_result got %h exp 000", {cout8, sum8}); else pass_cnt++;
        total_cnt++; if (ir1 !== 1'b1) $display("FAIL reset_in_ready_w1 got %b exp 1", ir1); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input logic [7:0] ai, input logic [7:0] bi, input logic ci);
        int lat; logic [7:0] s; logic c; logic [8:0] exp_v;
        exp_v = ref_add8(ai, bi, ci);
        total_cnt++; if (ir8 !== 1'b1) $display("FAIL basic_ready got %b exp 1", ir8); else pass_cnt++;
        op8(ai, bi, ci, lat, s, c);
        total_cnt++; if (lat !== 8) $display("FAIL basic_latency %h+%h got %0d exp 8", ai, bi, lat); else pass_cnt++;
        total_cnt++; if ({c, s} !== exp_v) $display("FAIL basic_sum %h+%h+%b got %h exp %h", ai, bi, ci, {c, s}, exp_v); else pass_cnt++;
        total_cnt++; if (busy8 !== 1'b1) $display("FAIL basic_busy_done got %b exp 1", busy8); else pass_cnt++;
        handoff8();
        total_cnt++; if (ir8 !== 1'b1 || ov8 !== 1'b0) $display("FAIL basic_handoff ir=%b ov=%b exp ir=1 ov=0", ir8, ov8); else pass_cnt++;
    endtask

    task automatic test_hold();
        int lat; logic [7:0] s; logic c;
        op8(8'h3C, 8'h42, 1'b0, lat, s, c);
        total_cnt++; if ({c, s} !== 9'h07E) $display("FAIL hold_sum got %h exp 07e", {c, s}); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (ov8 !== 1'b1 || {cout8, sum8} !== 9'h07E || ir8 !== 1'b0)
                $display("FAIL hold_cycle%0d ov=%b res=%h ir=%b exp ov=1 res=07e ir=0", i, ov8, {cout8, sum8}, ir8);
            else pass_cnt++;
        end
        handoff8();
        total_cnt++; if (ir8 !== 1'b1 || busy8 !== 1'b0) $display("FAIL hold_release ir=%b busy=%b exp 1 0", ir8, busy8); else pass_cnt++;
        total_cnt++; if ({cout8, sum8} !== 9'h07E) $display("FAIL hold_keep_after got %h exp 07e", {cout8, sum8}); else pass_cnt++;
    endtask

    task automatic test_ignore_in_run();
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin iv8 = 1'b1; a8 = 8'h11; end
            else begin iv8 = 1'b0; end
            total_cnt++; if (ir8 !== 1'b0) $display("FAIL ignore_ready_c%0d got %b exp 0", i, ir8); else pass_cnt++;
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        total_cnt++; if (ov8 !== 1'b1 || {cout8, sum8} !== 9'h002) $display("FAIL ignore_result ov=%b res=%h exp 1 002", ov8, {cout8, sum8}); else pass_cnt++;
        total_cnt++; if (ir8 !== 1'b0) $display("FAIL ignore_ready_done got %b exp 0", ir8); else pass_cnt++;
        handoff8();
        total_cnt++; if (ir8 !== 1'b1) $display("FAIL ignore_ready_after got %b exp 1", ir8); else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat; logic [7:0] s; logic c;
        iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F; cin8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) begin @(posedge clk); end
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (ov8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h00 || ir8 !== 1'b1)
            $display("FAIL abort_state ov=%b busy=%b sum=%h ir=%b exp 0 0 00 1", ov8, busy8, sum8, ir8);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (ov8 !== 1'b0) $display("FAIL abort_no_valid got %b exp 0", ov8); else pass_cnt++;
        op8(8'h80, 8'h80, 1'b0, lat, s, c);
        total_cnt++; if ({c, s} !== 9'h100 || lat !== 8) $display("FAIL abort_next res=%h lat=%0d exp 100 8", {c, s}, lat); else pass_cnt++;
        handoff8();
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] s; logic c; logic [7:0] ai, bi; logic ci;
        for (int k = 0; k < 20; k++) begin
            ai = 8'($urandom); bi = 8'($urandom); ci = 1'($urandom);
            total_cnt++; if (ir8 !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", k, ir8); else pass_cnt++;
            op8(ai, bi, ci, lat, s, c);
            total_cnt++;
            if ({c, s} !== ref_add8(ai, bi, ci) || lat !== 8)
                $display("FAIL b2b_op%0d %h+%h+%b got %h lat=%0d exp %h lat=8", k, ai, bi, ci, {c, s}, lat, ref_add8(ai, bi, ci));
            else pass_cnt++;
            handoff8();
        end
    endtask

    task automatic test_width1();
        logic [1:0] exp_v; logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            total_cnt++; if (ir1 !== 1'b1) $display("FAIL w1_ready%0d got %b exp 1", i, ir1); else pass_cnt++;
            exp_v = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            iv1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
            @(posedge clk); #1;
            iv1 = 1'b0;
            total_cnt++; if (ov1 !== 1'b0) $display("FAIL w1_early%0d got %b exp 0", i, ov1); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (ov1 !== 1'b1 || {cout1, sum1} !== exp_v)
                $display("FAIL w1_combo%0d ov=%b res=%b exp ov=1 res=%b", i, ov1, {cout1, sum1}, exp_v);
            else pass_cnt++;
            or1 = 1'b1;
            @(posedge clk); #1;
            or1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'h00, 8'h00, 1'b0);
        test_basic(8'hFF, 8'h01, 1'b0);
        test_basic(8'hA5, 8'h5A, 1'b1);
        test_basic(8'hFF, 8'hFF, 1'b1);
        test_hold();
        test_ignore_in_run();
        test_abort();
        test_back_to_back();
        test_width1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
